// File: rtl/aibnd_clkgate_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aibnd_clkgate_seq_pkg
// Brief    : Shared state encoding and defaults for the clock-gate sequencer.
// Revision : 1.0
// ============================================================================
package aibnd_clkgate_seq_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    localparam int DEF_NUM_BR     = 4;
    localparam int DEF_SETTLE_CYC = 8;

endpackage
`default_nettype wire

// File: rtl/aibnd_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : aibnd_rr_arb
// Brief    : Combinational round-robin pick; first request after ptr, wrapping.
// Revision : 1.0
// ============================================================================
module aibnd_rr_arb #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] w_cand [N];
    logic          w_found;

    // w_cand[k] is the index holding priority rank k (ptr+1 is highest)
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_cand[k] = IW'((int'(ptr) + k + 1) % N);
        end
    end

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[w_cand[k]]) begin
                w_found          = 1'b1;
                gnt[w_cand[k]]   = 1'b1;
                idx              = w_cand[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aibnd_clkgate_seq.sv
`default_nettype none
// ============================================================================
// Module   : aibnd_clkgate_seq
// Brief    : Sequences NAND clock-gate enables one branch at a time with settle.
// Revision : 1.0
// ============================================================================
module aibnd_clkgate_seq
    import aibnd_clkgate_seq_pkg::*;
#(
    parameter int NUM_BR     = DEF_NUM_BR,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_BR-1:0] req_i,
    output logic [NUM_BR-1:0] en_o,
    output logic [NUM_BR-1:0] ack_o,
    output logic              busy_o,
    input  logic              vccl_aibnd,
    input  logic              vssl_aibnd
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam int PW    = $clog2(NUM_BR);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [NUM_BR-1:0]   r_en_state, w_en_nxt;
    logic [NUM_BR-1:0]   r_ack, w_ack_nxt;
    logic [PW-1:0]       r_rr_ptr, w_ptr_nxt;
    logic [NUM_BR-1:0]   r_en_neg;
    logic [NUM_BR-1:0]   w_pend;
    logic [NUM_BR-1:0]   w_gnt;
    logic [PW-1:0]       w_gidx;
    logic                w_unused;

    assign w_unused = vccl_aibnd ^ vssl_aibnd;
    assign w_pend   = req_i ^ r_en_state;

    aibnd_rr_arb #(.N(NUM_BR), .IW(PW)) u_arb (
        .req (w_pend),
        .ptr (r_rr_ptr),
        .gnt (w_gnt),
        .idx (w_gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_en_state <= '0;
            r_ack      <= '0;
            r_rr_ptr   <= PW'(NUM_BR - 1);
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_en_state <= w_en_nxt;
            r_ack      <= w_ack_nxt;
            r_rr_ptr   <= w_ptr_nxt;
        end
    end

    // During SETTLE r_rr_ptr still names the branch being switched
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = r_en_state;
        w_ack_nxt   = r_ack;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|w_pend) begin
                    w_en_nxt    = r_en_state ^ w_gnt;
                    w_ptr_nxt   = w_gidx;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_ack_nxt[r_rr_ptr] = r_en_state[r_rr_ptr];
                    w_state_nxt         = ST_IDLE;
                end
            end
        endcase
    end

    // Launch enables while clk is low so the NAND gate output cannot glitch
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_en_neg <= '0;
        end else begin
            r_en_neg <= r_en_state;
        end
    end

    assign en_o   = r_en_neg;
    assign ack_o  = r_ack;
    assign busy_o = (r_state == ST_SETTLE);

endmodule
`default_nettype wire

// File: tb/tb_aibnd_clkgate_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aibnd_clkgate_seq
// Brief    : Randomized and directed bench against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_aibnd_clkgate_seq;

    localparam int NB = 4;
    localparam int SC = 8;
    localparam int HP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NB-1:0] req_i = '0;
    logic [NB-1:0] en_o;
    logic [NB-1:0] ack_o;
    logic          busy_o;

    int total = 0;
    int bad   = 0;

    aibnd_clkgate_seq #(.NUM_BR(NB), .SETTLE_CYC(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .en_o       (en_o),
        .ack_o      (ack_o),
        .busy_o     (busy_o),
        .vccl_aibnd (1'b1),
        .vssl_aibnd (1'b0)
    );

    always #HP clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: en/ack levels, last granted branch, cycles left in window
    logic [NB-1:0] m_en, m_ack;
    int            m_last, m_left;

    always @(posedge clk or posedge rst) begin
        int  g;
        bit  found;
        if (rst) begin
            m_en = '0; m_ack = '0; m_last = NB - 1; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_ack[m_last] = m_en[m_last];
        end else begin
            found = 0;
            for (int k = 1; k <= NB; k++) begin
                g = (m_last + k) % NB;
                if (!found && req_i[g] != m_en[g]) begin
                    found = 1; m_en[g] = req_i[g]; m_last = g; m_left = SC;
                end
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            check("en", en_o, m_en);
            check("ack", ack_o, m_ack);
            check("busy", busy_o, m_left > 0);
        end
    end

    logic [NB-1:0] prev_en = '0;
    always @(en_o) begin
        if (!rst) begin
            check("en_clk_low", clk, 1'b0);
            check("en_onebit", $countones(en_o ^ prev_en) <= 1, 1'b1);
        end
        prev_en = en_o;
    end

    wire [NB-1:0]  clkout = ~({NB{clk}} & en_o);
    logic [NB-1:0] prev_co = '1;
    time           last_t [NB] = '{default: 0};
    always @(clkout) begin
        for (int i = 0; i < NB; i++) begin
            if (clkout[i] !== prev_co[i]) begin
                if (!rst && last_t[i] != 0) check("co_pulse", ($time - last_t[i]) >= HP, 1'b1);
                last_t[i] = rst ? 0 : $time;
            end
        end
        prev_co = clkout;
    end

    task automatic wait_quiet(input int lim);
        int n = 0;
        while (!(ack_o === req_i && busy_o === 1'b0) && n < lim) begin
            @(negedge clk); #2;
            n++;
        end
        check("quiet_to", n < lim, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_en", en_o, '0);
        check("rst_ack", ack_o, '0);
        check("rst_busy", busy_o, 1'b0);
        @(negedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        repeat (20) @(negedge clk);
        check("idle_en", en_o, '0);

        // single on, latency from request to ack
        @(negedge clk); #2;
        req_i = 4'b0001;
        n = 0;
        while (!ack_o[0] && n < 50) begin @(posedge clk); #1; n++; end
        check("on_lat", n, SC + 1);
        wait_quiet(100);

        // contention on, then all off
        @(negedge clk); #2; req_i = 4'b1111;
        wait_quiet(200);
        @(negedge clk); #2; req_i = 4'b0000;
        wait_quiet(200);

        // fairness: branch 0 keeps toggling while branch 2 waits
        @(negedge clk); #2; req_i = 4'b0101;
        n = 0;
        while (!ack_o[2] && n < 100) begin
            @(negedge clk); #2; n++;
            if (ack_o[0] == req_i[0]) req_i[0] = ~req_i[0];
        end
        check("fair", n <= NB * (SC + 1), 1'b1);
        req_i = 4'b0000;
        wait_quiet(200);

        // withdrawal mid-settle
        @(negedge clk); #2; req_i[1] = 1'b1;
        repeat (3) @(negedge clk);
        #2; req_i[1] = 1'b0;
        wait_quiet(200);
        check("wd_ack", ack_o[1], 1'b0);

        // random traffic with a reset in the middle
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #2;
            if ($urandom_range(0, 5) == 0) req_i = NB'($urandom);
            if (c == 300) begin
                do_reset();
            end
        end
        wait_quiet(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
